base_arr_demux: RTL and testbench

- Single-input, N-way valid/ready fork (demultiplexer) with per-beat destination mask.
- It is the distribution-side counterpart of the arbitrated N-to-1 mux. One upstream stream fans out to one or more downstream ways, unicast or multicast.
- A one-entry holding stage registers each beat. Per-way completion is tracked so that downstream ways may accept a multicast beat on different cycles.

---
 rtl/base_arr_demux.sv | 82 ++++++++
 tb/tb_base_arr_demux.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/base_arr_demux.sv
// One-input, N-way valid/ready fork with a per-beat destination mask.
// A single holding register tracks, per way, which ways have already taken the held beat.
module base_arr_demux #(
    parameter int unsigned ways  = 2,
    parameter int unsigned width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_v,
    output logic             i_r,
    input  logic [width-1:0] i_d,
    input  logic [ways-1:0]  i_sel,
    output logic [ways-1:0]  o_v,
    input  logic [ways-1:0]  o_r,
    output logic [width-1:0] o_d,
    output logic [ways-1:0]  o_sel,
    output logic             o_drop
);

    logic             s_v_q,    s_v_d;
    logic [width-1:0] s_d_q,    s_d_d;
    logic [ways-1:0]  s_sel_q,  s_sel_d;
    logic [ways-1:0]  s_done_q, s_done_d;
    logic             drop_q,   drop_d;

    logic [ways-1:0]  xfer;
    logic [ways-1:0]  done_or_xfer;
    logic             cmpl;
    logic             accept;

    always_comb begin
        o_v          = {ways{s_v_q}} & s_sel_q & ~s_done_q;
        xfer         = o_v & o_r;
        done_or_xfer = s_done_q | xfer;
        cmpl         = s_v_q && ((s_sel_q & ~done_or_xfer) == '0);
        i_r          = ~reset & (~s_v_q | cmpl);
        accept       = i_v & i_r;

        s_v_d    = s_v_q;
        s_d_d    = s_d_q;
        s_sel_d  = s_sel_q;
        s_done_d = s_done_q;
        drop_d   = accept && (i_sel == '0);

        // A zero-mask accept is never loaded; the holding stage just follows completion.
        if (accept && (i_sel != '0)) begin
            s_v_d    = 1'b1;
            s_d_d    = i_d;
            s_sel_d  = i_sel;
            s_done_d = '0;
        end else if (cmpl) begin
            s_v_d    = 1'b0;
            s_done_d = '0;
        end else begin
            s_done_d = done_or_xfer;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_v_q    <= 1'b0;
            s_sel_q  <= '0;
            s_done_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            s_v_q    <= s_v_d;
            s_sel_q  <= s_sel_d;
            s_done_q <= s_done_d;
            drop_q   <= drop_d;
        end
    end

    // Data is qualified by s_v, so it needs no reset.
    always_ff @(posedge clk) begin
        s_d_q <= s_d_d;
    end

    assign o_d    = s_d_q;
    assign o_sel  = s_sel_q;
    assign o_drop = drop_q;

endmodule

// File: tb/tb_base_arr_demux.sv
// Directed bench for base_arr_demux (4 ways, 8-bit data) with a per-way scoreboard.
module tb_base_arr_demux;

    localparam int unsigned W = 4;
    localparam int unsigned D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_v;
    logic         i_r;
    logic [D-1:0] i_d;
    logic [W-1:0] i_sel;
    logic [W-1:0] o_v;
    logic [W-1:0] o_r;
    logic [D-1:0] o_d;
    logic [W-1:0] o_sel;
    logic         o_drop;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned drops_exp = 0;
    int unsigned drops_seen = 0;
    logic [D-1:0] exp_q [W][$];

    base_arr_demux #(.ways(W), .width(D)) dut (
        .clk(clk), .reset(reset),
        .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_sel(i_sel),
        .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_sel(o_sel), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, then let combinational outputs settle.
    task automatic cyc(input logic v, input logic [W-1:0] sel, input logic [D-1:0] d,
                       input logic [W-1:0] r);
        @(posedge clk);
        #1;
        i_v = v; i_sel = sel; i_d = d; o_r = r;
        #1;
    endtask

    // Stimulus-side observer: every accepted beat queues its data for each selected way.
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < W; k++) exp_q[k].delete();
        end else if (i_v && i_r) begin
            if (i_sel == '0) drops_exp++;
            for (int k = 0; k < W; k++)
                if (i_sel[k]) exp_q[k].push_back(i_d);
        end
    end

    // Output monitor: each per-way transfer must match the oldest queued beat for that way.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_drop) drops_seen++;
            for (int k = 0; k < W; k++) begin
                if (o_v[k] && o_r[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        errors++;
                        $display("FAIL way%0d_unexpected: got %0h expected nothing", k, o_d);
                    end else begin
                        logic [D-1:0] e;
                        e = exp_q[k].pop_front();
                        if (o_d !== e) begin
                            errors++;
                            $display("FAIL way%0d_data: got %0h expected %0h", k, o_d, e);
                        end
                    end
                end
            end
        end
    end

    logic [W-1:0] mix_sel [6] = '{4'b0101, 4'b0011, 4'b1111, 4'b0000, 4'b1000, 4'b0110};
    logic [D-1:0] mix_dat [6] = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    logic [W-1:0] mix_r   [5] = '{4'b0101, 4'b1010, 4'b1111, 4'b0000, 4'b0011};

    initial begin
        int idx;
        int n;
        reset = 1'b1; i_v = 1'b0; i_sel = '0; i_d = '0; o_r = '0;
        #1;
        chk("rst_o_v", o_v, 0);
        chk("rst_i_r", i_r, 0);
        chk("rst_o_drop", o_drop, 0);
        chk("rst_o_sel", o_sel, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Unicast streaming to way 2
        cyc(1'b1, 4'b0100, 8'h10, 4'b1111);
        chk("uni_first_i_r", i_r, 1);
        chk("uni_first_o_v", o_v, 0);
        for (int j = 1; j < 8; j++) begin
            cyc(1'b1, 4'b0100, 8'(8'h10 + j), 4'b1111);
            chk("uni_o_v", o_v, 4'b0100);
            chk("uni_o_d", o_d, 8'h10 + j - 1);
            chk("uni_i_r", i_r, 1);
        end
        cyc(1'b0, 4'b0000, 8'h00, 4'b1111);
        chk("uni_last_o_d", o_d, 8'h17);
        cyc(1'b0, 4'b0000, 8'h00, 4'b1111);
        chk("uni_idle_o_v", o_v, 0);

        // Staggered multicast to ways 0,1,3 with the next beat waiting
        cyc(1'b1, 4'b1011, 8'hA5, 4'b0000);
        chk("mc_load_i_r", i_r, 1);
        cyc(1'b1, 4'b0001, 8'h5A, 4'b1000);
        chk("mc_c1_o_v", o_v, 4'b1011);
        chk("mc_c1_o_d", o_d, 8'hA5);
        chk("mc_c1_i_r", i_r, 0);
        cyc(1'b1, 4'b0001, 8'h5A, 4'b0010);
        chk("mc_c2_o_v", o_v, 4'b0011);
        chk("mc_c2_i_r", i_r, 0);
        cyc(1'b1, 4'b0001, 8'h5A, 4'b0001);
        chk("mc_c3_o_v", o_v, 4'b0001);
        chk("mc_c3_i_r", i_r, 1);
        cyc(1'b0, 4'b0000, 8'h00, 4'b0001);
        chk("mc_next_o_v", o_v, 4'b0001);
        chk("mc_next_o_d", o_d, 8'h5A);
        cyc(1'b0, 4'b0000, 8'h00, 4'b0000);
        chk("mc_idle_o_v", o_v, 0);

        // Backpressure on way 0
        cyc(1'b1, 4'b0001, 8'h77, 4'b0000);
        chk("bp_load_i_r", i_r, 1);
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1, 4'b0001, 8'(8'h80 + j), 4'b0000);
            chk("bp_o_v", o_v, 4'b0001);
            chk("bp_o_d", o_d, 8'h77);
            chk("bp_i_r", i_r, 0);
        end
        cyc(1'b1, 4'b0001, 8'h99, 4'b0001);
        chk("bp_rel_o_d", o_d, 8'h77);
        chk("bp_rel_i_r", i_r, 1);
        cyc(1'b0, 4'b0000, 8'h00, 4'b0001);
        chk("bp_next_o_d", o_d, 8'h99);
        chk("bp_next_o_v", o_v, 4'b0001);
        cyc(1'b0, 4'b0000, 8'h00, 4'b0000);
        chk("bp_idle_o_v", o_v, 0);

        // Zero-mask drop while empty, then behind a completing unicast
        cyc(1'b1, 4'b0000, 8'h3C, 4'b0000);
        chk("drop_i_r", i_r, 1);
        chk("drop_o_drop0", o_drop, 0);
        cyc(1'b0, 4'b0000, 8'h00, 4'b0000);
        chk("drop_pulse", o_drop, 1);
        chk("drop_o_v", o_v, 0);
        chk("drop_after_i_r", i_r, 1);
        cyc(1'b0, 4'b0000, 8'h00, 4'b0000);
        chk("drop_end", o_drop, 0);
        cyc(1'b1, 4'b0100, 8'h42, 4'b1111);
        cyc(1'b1, 4'b0000, 8'h3C, 4'b1111);
        chk("b2b_o_v", o_v, 4'b0100);
        chk("b2b_i_r", i_r, 1);
        cyc(1'b0, 4'b0000, 8'h00, 4'b1111);
        chk("b2b_pulse", o_drop, 1);
        chk("b2b_o_v_idle", o_v, 0);
        cyc(1'b0, 4'b0000, 8'h00, 4'b1111);
        chk("b2b_end", o_drop, 0);

        // Reset in the middle of a partially delivered multicast
        cyc(1'b1, 4'b1111, 8'hC3, 4'b0000);
        cyc(1'b0, 4'b0000, 8'h00, 4'b0011);
        chk("mr_o_v", o_v, 4'b1111);
        chk("mr_o_sel", o_sel, 4'b1111);
        cyc(1'b0, 4'b0000, 8'h00, 4'b0000);
        chk("mr_part_o_v", o_v, 4'b1100);
        chk("mr_part_i_r", i_r, 0);
        cyc(1'b0, 4'b0000, 8'h00, 4'b0000);
        reset = 1'b1;
        #1;
        chk("mr_rst_o_v", o_v, 0);
        chk("mr_rst_i_r", i_r, 0);
        chk("mr_rst_o_sel", o_sel, 0);
        cyc(1'b0, 4'b0000, 8'h00, 4'b1111);
        reset = 1'b0;
        #1;
        chk("mr_rel_i_r", i_r, 1);
        chk("mr_rel_o_v", o_v, 0);
        cyc(1'b0, 4'b0000, 8'h00, 4'b1111);
        chk("mr_after_o_v", o_v, 0);

        // Mixed masks against rotating ready patterns, checked by the scoreboard
        idx = 0;
        n = 0;
        while (idx < 6 && n < 200) begin
            cyc(1'b1, mix_sel[idx], mix_dat[idx], mix_r[n % 5]);
            if (i_r) idx++;
            n++;
        end
        chk("mix_all_accepted", idx, 6);
        cyc(1'b0, 4'b0000, 8'h00, 4'b1111);
        n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && n < 50) begin
            cyc(1'b0, 4'b0000, 8'h00, 4'b1111);
            n++;
        end
        repeat (2) cyc(1'b0, 4'b0000, 8'h00, 4'b1111);
        for (int k = 0; k < W; k++) chk("drain_empty", exp_q[k].size(), 0);
        chk("final_o_v", o_v, 0);
        chk("drop_count_model", drops_exp, 3);
        chk("drop_count_seen", drops_seen, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
